// File: rtl/sipo_pkg.sv
// Shared types and width helpers for the SIPO frame receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int tmr_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sipo_rx_ctrl_if.sv
// Bit-in / word-out bundle between serial source, controller and consumer.
interface sipo_rx_ctrl_if #(
  parameter int WIDTH = 4
);
  import sipo_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  logic             start;
  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;
  logic             clr_ovr;
  logic             frame_err;

  modport master (
    output start, sin, sin_valid, out_ready, clr_ovr,
    input  dout, out_valid, busy, bit_cnt, overrun, frame_err
  );

  modport slave (
    input  start, sin, sin_valid, out_ready, clr_ovr,
    output dout, out_valid, busy, bit_cnt, overrun, frame_err
  );

endinterface

// File: rtl/sipo_shreg.sv
// Shift register: serial in at the MSB, contents move toward bit 0.
module sipo_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= {sin_i, q_q[WIDTH-1:1]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller: counts WIDTH bits into the shift register, holds the
// finished word on a valid/ready port, flags overrun and frame timeout.
module sipo_rx_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 0
) (
  input logic           clk,
  input logic           rst,
  sipo_rx_ctrl_if.slave rx
);

  localparam int CW = cnt_w(WIDTH);
  localparam int TW = tmr_w(TIMEOUT);
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [TW-1:0]    tmr_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_nxt;
  logic             ovalid_q;
  logic             busy_q;
  logic             ovr_q;
  logic             ferr_q;
  logic             sh_clr;
  logic             sh_en;
  logic             tmo;
  logic             unused_lsb;

  // start clears the register unless a pending word blocks it
  assign sh_clr = rx.start &&
    ((state_q != HOLD) || rx.out_ready);
  assign sh_en  = (state_q == SHIFT) &&
    rx.sin_valid && !rx.start;
  assign sh_nxt = {rx.sin, sh_q[WIDTH-1:1]};
  assign tmo    = (TIMEOUT > 0) && (tmr_q == TLAST);
  assign unused_lsb = sh_q[0];

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .clr_i (sh_clr),
    .en_i  (sh_en),
    .sin_i (rx.sin),
    .q_o   (sh_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmr_q    <= '0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (rx.clr_ovr) ovr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx.start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            tmr_q   <= '0;
          end
        end
        SHIFT: begin
          if (rx.start) begin
            cnt_q <= '0;
            tmr_q <= '0;
          end else if (rx.sin_valid) begin
            tmr_q <= '0;
            if (cnt_q == CLAST) begin
              dout_q   <= sh_nxt;
              ovalid_q <= 1'b1;
              busy_q   <= 1'b0;
              cnt_q    <= '0;
              state_q  <= HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (tmo) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            ferr_q  <= 1'b1;
          end else if (TIMEOUT > 0) begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        HOLD: begin
          // a set in the same cycle as clr_ovr overrides the clear
          if (rx.sin_valid) ovr_q <= 1'b1;
          if (rx.out_ready) begin
            ovalid_q <= 1'b0;
            if (rx.start) begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              tmr_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.dout      = dout_q;
  assign rx.out_valid = ovalid_q;
  assign rx.busy      = busy_q;
  assign rx.bit_cnt   = cnt_q;
  assign rx.overrun   = ovr_q;
  assign rx.frame_err = ferr_q;

endmodule
